// File: rtl/fetch_pkg.sv
// Shared fetch-path types: default widths, the fetch entry layout and flush modes.
package fetch_pkg;

   localparam int PC_W_DEF    = 7;
   localparam int INSTR_W_DEF = 32;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
      logic                   squash;
   } fetch_entry_t;

   typedef enum logic {
      FLUSH_DROP = 1'b0,
      FLUSH_MARK = 1'b1
   } flush_mode_e;

endpackage

// File: rtl/fetch_skid_stage.sv
// Fetch-to-decode stage: two-slot skid buffer (main + skid) with registered in_ready
// and a synchronous flush that either drops or squash-marks the held entries.
module fetch_skid_stage
   import fetch_pkg::*;
#(
   parameter int              PC_W         = PC_W_DEF,
   parameter int              INSTR_W      = INSTR_W_DEF,
   parameter int              RESET_SQUASH = 1,
   parameter int              FLUSH_MODE   = 0,
   parameter logic [PC_W-1:0] RESET_PC     = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_squash,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               out_squash,
   output logic [1:0]         occupancy
);

   // Same field order as fetch_entry_t, widened to this instance's parameters.
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               squash;
   } entry_t;

   localparam flush_mode_e MODE    = flush_mode_e'(FLUSH_MODE[0]);
   localparam logic        RST_VLD = (RESET_SQUASH != 0);
   localparam entry_t      RST_ENTRY = '{
      pc:     (RESET_SQUASH != 0) ? RESET_PC : '0,
      instr:  '0,
      squash: RST_VLD
   };

   entry_t main_q, skid_q, main_d, skid_d, in_entry;
   logic   main_vld, skid_vld, main_vld_d, skid_vld_d;
   logic   in_fire, out_fire;

   assign in_entry  = '{pc: in_pc, instr: in_instr, squash: in_squash};
   assign in_ready  = ~skid_vld;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_vld & out_ready;

   assign out_valid  = main_vld;
   assign out_pc     = main_q.pc;
   assign out_instr  = main_q.instr;
   assign out_squash = main_q.squash;
   assign occupancy  = {1'b0, main_vld} + {1'b0, skid_vld};

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld;
      skid_vld_d = skid_vld;
      if (flush_in && MODE == FLUSH_DROP) begin
         // A concurrent out_fire needs no action: decode already took the entry.
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (!main_vld) begin
            if (in_fire) begin
               main_d     = in_entry;
               main_vld_d = 1'b1;
            end
         end else if (!skid_vld) begin
            if (in_fire && out_fire) begin
               main_d = in_entry;
            end else if (in_fire) begin
               skid_d     = in_entry;
               skid_vld_d = 1'b1;
            end else if (out_fire) begin
               main_vld_d = 1'b0;
            end
         end else if (out_fire) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
         // Marking invalid slots too is harmless since their data is don't-care.
         if (flush_in && MODE == FLUSH_MARK) begin
            main_d.squash = 1'b1;
            skid_d.squash = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld <= RST_VLD;
         main_q   <= RST_ENTRY;
         skid_vld <= 1'b0;
         skid_q   <= '0;
      end else begin
         main_vld <= main_vld_d;
         main_q   <= main_d;
         skid_vld <= skid_vld_d;
         skid_q   <= skid_d;
      end
   end

endmodule

// File: tb/tb_fetch_skid_stage.sv
// Bench for fetch_skid_stage: a drop-mode and a mark-mode instance share one stimulus,
// each checked every cycle against an in-order FIFO model plus literal spot checks.
module tb_fetch_skid_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_in, in_valid, in_squash, out_ready;
   logic [6:0]  in_pc;
   logic [31:0] in_instr;

   logic        in_ready  [2];
   logic        out_valid [2];
   logic [6:0]  out_pc    [2];
   logic [31:0] out_instr [2];
   logic        out_squash[2];
   logic [1:0]  occupancy [2];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fetch_skid_stage #(.FLUSH_MODE(0)) dut_drop (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(in_ready[0]), .in_pc(in_pc),
      .in_instr(in_instr), .in_squash(in_squash),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_pc(out_pc[0]),
      .out_instr(out_instr[0]), .out_squash(out_squash[0]), .occupancy(occupancy[0])
   );

   fetch_skid_stage #(.FLUSH_MODE(1)) dut_mark (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(in_ready[1]), .in_pc(in_pc),
      .in_instr(in_instr), .in_squash(in_squash),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_pc(out_pc[1]),
      .out_instr(out_instr[1]), .out_squash(out_squash[1]), .occupancy(occupancy[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: each stage is an in-order queue of capacity 2 (index 0 = oldest).
   fetch_entry_t mq [2][2];
   int           mcnt[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            mq[d][0] <= '{pc: 7'd0, instr: 32'd0, squash: 1'b1};
            mq[d][1] <= '0;
            mcnt[d]  <= 1;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            automatic fetch_entry_t q[2];
            automatic int n = mcnt[d];
            automatic bit accept = in_valid && (n < 2);
            q[0] = mq[d][0];
            q[1] = mq[d][1];
            if (n > 0 && out_ready) begin
               q[0] = q[1];
               n--;
            end
            if (flush_in && d == 0) begin
               n = 0;
            end else begin
               if (accept) begin
                  q[n] = '{pc: in_pc, instr: in_instr, squash: in_squash};
                  n++;
               end
               if (flush_in && d == 1)
                  for (int i = 0; i < n; i++) q[i].squash = 1'b1;
            end
            mq[d][0] <= q[0];
            mq[d][1] <= q[1];
            mcnt[d]  <= n;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("occupancy[%0d]", d), 32'(occupancy[d]), 32'(mcnt[d]));
            check($sformatf("out_valid[%0d]", d), 32'(out_valid[d]), 32'(mcnt[d] > 0));
            check($sformatf("in_ready[%0d]", d), 32'(in_ready[d]), 32'(mcnt[d] < 2));
            if (mcnt[d] > 0) begin
               check($sformatf("out_pc[%0d]", d), 32'(out_pc[d]), 32'(mq[d][0].pc));
               check($sformatf("out_instr[%0d]", d), out_instr[d], mq[d][0].instr);
               check($sformatf("out_squash[%0d]", d), 32'(out_squash[d]), 32'(mq[d][0].squash));
            end
         end
      end
   end

   // Apply one cycle of inputs, then step past the next rising edge.
   task automatic drive(input logic v, input logic [6:0] pc, input logic sq,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = 32'hA000_0000 | 32'(pc);
      in_squash = sq;
      out_ready = ordy;
      flush_in  = fl;
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s out_valid[%0d]", tag, d), 32'(out_valid[d]), 32'd1);
         check($sformatf("%s out_squash[%0d]", tag, d), 32'(out_squash[d]), 32'd1);
         check($sformatf("%s out_pc[%0d]", tag, d), 32'(out_pc[d]), 32'd0);
         check($sformatf("%s occupancy[%0d]", tag, d), 32'(occupancy[d]), 32'd1);
         check($sformatf("%s in_ready[%0d]", tag, d), 32'(in_ready[d]), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      flush_in = 1'b0; in_valid = 1'b0; in_squash = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_instr = '0;
      #12;
      rst_n = 1'b1;
      #1;
      check_reset_vals("reset");
      @(negedge clk); #1;
      check("token gone occupancy", 32'(occupancy[0]), 32'd0);
      check("token gone out_valid", 32'(out_valid[0]), 32'd0);

      // Streaming at full rate, PC 4 arrives pre-squashed.
      for (int p = 1; p <= 8; p++) begin
         drive(1'b1, 7'(p), (p == 4), 1'b1, 1'b0);
         if (p == 1) check("stream first pc", 32'(out_pc[0]), 32'd1);
      end
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

      // Backpressure fills the skid slot, then drains in order.
      drive(1'b1, 7'd5, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd6, 1'b0, 1'b0, 1'b0);
      check("stall occupancy", 32'(occupancy[0]), 32'd2);
      check("stall in_ready", 32'(in_ready[0]), 32'd0);
      drive(1'b1, 7'd7, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd7, 1'b0, 1'b1, 1'b0);
      check("drain pc6", 32'(out_pc[0]), 32'd6);
      drive(1'b1, 7'd7, 1'b0, 1'b1, 1'b0);
      check("drain pc7", 32'(out_pc[0]), 32'd7);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

      // Flush with both slots full and PC 9 offered.
      drive(1'b1, 7'd10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd9, 1'b0, 1'b0, 1'b1);
      check("drop flush occupancy", 32'(occupancy[0]), 32'd0);
      check("drop flush out_valid", 32'(out_valid[0]), 32'd0);
      check("mark flush occupancy", 32'(occupancy[1]), 32'd2);
      check("mark flush pc", 32'(out_pc[1]), 32'd10);
      check("mark flush squash", 32'(out_squash[1]), 32'd1);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      check("mark second pc", 32'(out_pc[1]), 32'd11);
      check("mark second squash", 32'(out_squash[1]), 32'd1);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

      // Flush at occupancy 1 with a concurrent accept and output fire.
      drive(1'b1, 7'd12, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd13, 1'b0, 1'b1, 1'b1);
      check("drop flush2 occupancy", 32'(occupancy[0]), 32'd0);
      check("mark flush2 pc", 32'(out_pc[1]), 32'd13);
      check("mark flush2 squash", 32'(out_squash[1]), 32'd1);
      check("mark flush2 occupancy", 32'(occupancy[1]), 32'd1);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset while full, then release with a flush pending.
      drive(1'b1, 7'd20, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 7'd21, 1'b0, 1'b0, 1'b0);
      check("pre-reset occupancy", 32'(occupancy[0]), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async reset");
      in_valid = 1'b0; out_ready = 1'b0; flush_in = 1'b1;
      @(negedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
      check("reset+flush drop occupancy", 32'(occupancy[0]), 32'd0);
      check("reset+flush mark occupancy", 32'(occupancy[1]), 32'd1);
      check("reset+flush mark squash", 32'(out_squash[1]), 32'd1);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
